// File: rtl/ulpb_ext_int_ctrl_pkg.sv
// rtl/ulpb_ext_int_ctrl_pkg.sv - shared state encodings and helpers for the external interrupt controller
package ulpb_ext_int_ctrl_pkg;

  // 2-bit state encodings, kept as plain constants so legacy code can share them
  localparam logic [1:0] EI_IDLE    = 2'd0;
  localparam logic [1:0] EI_WAIT    = 2'd1;
  localparam logic [1:0] EI_ASSERT  = 2'd2;
  localparam logic [1:0] EI_RELEASE = 2'd3;

  // High-to-low transition between a delayed sample and the current sample
  function automatic logic fell(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/ulpb_sync2.sv
// rtl/ulpb_sync2.sv - two-flop synchronizer with a configurable reset value
//
// Ports:
//   clk    in  - destination clock
//   resetn in  - synchronous active-low reset, loads RST_VAL into both flops
//   d      in  - asynchronous input
//   q      out - synchronized output
module ulpb_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ulpb_ext_int_ctrl.sv
// rtl/ulpb_ext_int_ctrl.sv - sequences EXTERNAL_INT to wake the MBus master
//
// Waits for the ring to be idle, forces the node's data output low through
// EXTERNAL_INT, watches the synchronized bus clock for the master's response
// and reports completion or timeout back to the layer.
//
// Ports:
//   CLK          in  - block clock
//   RESETn       in  - synchronous active-low reset
//   INT_REQ      in  - single-cycle interrupt request from the layer
//   DIN          in  - asynchronous ring data from the upstream node
//   CLKIN        in  - asynchronous ring clock from the upstream node
//   EXTERNAL_INT out - registered; high forces the wire controller's DOUT low
//   INT_BUSY     out - registered; state is not IDLE or a request is pending
//   INT_DONE     out - one-cycle pulse, the master responded
//   INT_FAIL     out - one-cycle pulse, no response before HOLD_MAX cycles
module ulpb_ext_int_ctrl
  import ulpb_ext_int_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 4,
  parameter int HOLD_MAX    = 255,
  parameter int CNT_W       = 8
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic INT_REQ,
  input  logic DIN,
  input  logic CLKIN,
  output logic EXTERNAL_INT,
  output logic INT_BUSY,
  output logic INT_DONE,
  output logic INT_FAIL
);

  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic             din_s;
  logic             clk_s;
  logic             clk_s_d;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             pending;
  logic             pending_nxt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic             ext_nxt;
  logic             done_nxt;
  logic             fail_nxt;
  logic             clk_fall;

  // Bus idles high, so both synchronizers come out of reset reading 1
  ulpb_sync2 #(.RST_VAL(1'b1)) u_sync_din (
    .clk    (CLK),
    .resetn (RESETn),
    .d      (DIN),
    .q      (din_s)
  );

  ulpb_sync2 #(.RST_VAL(1'b1)) u_sync_clk (
    .clk    (CLK),
    .resetn (RESETn),
    .d      (CLKIN),
    .q      (clk_s)
  );

  assign clk_fall = fell(clk_s_d, clk_s);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending | INT_REQ;
    ext_nxt     = 1'b0;
    done_nxt    = 1'b0;
    fail_nxt    = 1'b0;
    case (state)
      EI_IDLE: begin
        if (INT_REQ || pending) state_nxt = EI_WAIT;
      end
      EI_WAIT: begin
        // Entering ASSERT consumes every request merged so far
        if (idle_cnt == IDLE_MAX) begin
          state_nxt   = EI_ASSERT;
          ext_nxt     = 1'b1;
          pending_nxt = 1'b0;
        end
      end
      EI_ASSERT: begin
        ext_nxt = 1'b1;
        // A master response on the timeout cycle still counts as success
        if (clk_fall) begin
          state_nxt = EI_RELEASE;
          ext_nxt   = 1'b0;
          done_nxt  = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = EI_RELEASE;
          ext_nxt   = 1'b0;
          fail_nxt  = 1'b1;
        end
      end
      EI_RELEASE: begin
        // Hold off until the forced-low data has come back around the ring
        if (din_s) state_nxt = EI_IDLE;
      end
      default: state_nxt = EI_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state        <= EI_IDLE;
      pending      <= 1'b0;
      idle_cnt     <= '0;
      hold_cnt     <= '0;
      clk_s_d      <= 1'b1;
      EXTERNAL_INT <= 1'b0;
      INT_BUSY     <= 1'b0;
      INT_DONE     <= 1'b0;
      INT_FAIL     <= 1'b0;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      clk_s_d      <= clk_s;
      EXTERNAL_INT <= ext_nxt;
      INT_BUSY     <= (state_nxt != EI_IDLE) | pending_nxt;
      INT_DONE     <= done_nxt;
      INT_FAIL     <= fail_nxt;

      if (din_s && clk_s) begin
        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + CNT_W'(1);
      end else begin
        idle_cnt <= '0;
      end

      // Zero outside ASSERT, so every assertion starts counting from 0
      if (state == EI_ASSERT) hold_cnt <= hold_cnt + CNT_W'(1);
      else                    hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ulpb_ext_int_ctrl.sv
// tb/tb_ulpb_ext_int_ctrl.sv - scoreboard bench for ulpb_ext_int_ctrl
module tb_ulpb_ext_int_ctrl;

  localparam int IDLE_CYCLES = 4;
  localparam int HOLD_MAX    = 16;
  localparam int K_DONE      = 0;
  localparam int K_FAIL      = 1;
  localparam int K_ABORT     = 2;

  logic CLK     = 1'b0;
  logic RESETn  = 1'b0;
  logic INT_REQ = 1'b0;
  logic DIN     = 1'b1;
  logic CLKIN   = 1'b1;
  logic EXTERNAL_INT;
  logic INT_BUSY;
  logic INT_DONE;
  logic INT_FAIL;

  ulpb_ext_int_ctrl #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .HOLD_MAX    (HOLD_MAX),
    .CNT_W       (8)
  ) dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .INT_REQ      (INT_REQ),
    .DIN          (DIN),
    .CLKIN        (CLKIN),
    .EXTERNAL_INT (EXTERNAL_INT),
    .INT_BUSY     (INT_BUSY),
    .INT_DONE     (INT_DONE),
    .INT_FAIL     (INT_FAIL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int kind;
    int dur;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   mon_en  = 1'b0;
  logic prev_ext = 1'b0;
  int   hi_cnt  = 0;
  exp_t mon_e;
  int   act_kind;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ext(input logic level, input int bound, output int n);
    n = 0;
    while (EXTERNAL_INT !== level && n < bound) begin
      tick();
      n++;
    end
  endtask

  // Monitor: every falling EXTERNAL_INT pops one expected assertion
  always @(negedge CLK) begin
    if (mon_en) begin
      if (EXTERNAL_INT === 1'b1) hi_cnt++;
      if (prev_ext === 1'b1 && EXTERNAL_INT === 1'b0) begin
        if (INT_DONE === 1'b1 && INT_FAIL === 1'b0)      act_kind = K_DONE;
        else if (INT_FAIL === 1'b1 && INT_DONE === 1'b0) act_kind = K_FAIL;
        else if (INT_FAIL === 1'b0 && INT_DONE === 1'b0) act_kind = K_ABORT;
        else                                              act_kind = 3;
        check("release_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("release_kind", act_kind, mon_e.kind);
          if (mon_e.dur > 0) check("ext_int_high_cycles", hi_cnt, mon_e.dur);
        end
        hi_cnt = 0;
      end else begin
        check("pulse_without_release", {INT_DONE, INT_FAIL}, 0);
      end
      prev_ext = EXTERNAL_INT;
    end
  end

  // Called just after the edge on which EXTERNAL_INT rose. d is the cycle
  // count after the rise at which CLKIN is pulled low; the response is seen
  // three edges after the drive, so the master answers if d+2 <= HOLD_MAX.
  task automatic serve(input int d_in, input int nreq_in, output bit queued, output int exp_lat);
    int   d;
    int   nreq;
    int   loop_len;
    int   n;
    bit   drop_din;
    bit   done_case;
    exp_t e;
    d         = (d_in > 0) ? d_in : int'($urandom_range(1, 18));
    nreq      = (nreq_in >= 0) ? nreq_in : int'($urandom_range(0, 3));
    drop_din  = 1'($urandom_range(0, 1));
    done_case = (d + 2 <= HOLD_MAX);
    e.kind    = done_case ? K_DONE : K_FAIL;
    e.dur     = done_case ? d + 2 : HOLD_MAX;
    sb.push_back(e);
    loop_len = done_case ? d - 1 : 8;
    for (int i = 0; i < loop_len; i++) begin
      INT_REQ = ((i % 2) == 0) && (i < 2 * nreq);
      tick();
    end
    INT_REQ = 1'b0;
    queued  = (nreq > 0) && (loop_len > 0);
    if (done_case) begin
      CLKIN = 1'b0;
      if (drop_din) DIN = 1'b0;
    end
    wait_ext(1'b0, 2 * HOLD_MAX, n);
    check("release_within_bound", EXTERNAL_INT, 0);
    if (done_case && drop_din) begin
      repeat ($urandom_range(1, 4)) tick();
      check("busy_while_din_low", INT_BUSY, 1);
    end else if (done_case) begin
      repeat ($urandom_range(0, 4)) tick();
    end
    CLKIN = 1'b1;
    DIN   = 1'b1;
    // Done: bus back high now, 2 sync edges + IDLE_CYCLES + 1 edges to assert.
    // Fail: bus never left idle, RELEASE->IDLE->WAIT->ASSERT takes 3 edges.
    exp_lat = done_case ? IDLE_CYCLES + 3 : 3;
  endtask

  task automatic fresh_request();
    check("idle_before_req", INT_BUSY, 0);
    INT_REQ = 1'b1;
    tick();
    INT_REQ = 1'b0;
    check("wait_no_ext", EXTERNAL_INT, 0);
    check("busy_on_req", INT_BUSY, 1);
    tick();
    check("rise_one_edge_after_req", EXTERNAL_INT, 1);
  endtask

  task automatic run_chain(input int d_in, input int nreq_in);
    bit q;
    int lat;
    int n;
    int depth;
    serve(d_in, nreq_in, q, lat);
    depth = 0;
    while (q) begin
      wait_ext(1'b1, 40, n);
      check("queued_rise_latency", n, lat);
      depth++;
      serve(0, (depth < 3 && $urandom_range(0, 3) == 0) ? 1 : 0, q, lat);
    end
    repeat (12) tick();
    check("idle_after_chain", INT_BUSY, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_high;
    int n;

    // Reset with a request held high: nothing may leak through
    RESETn  = 1'b0;
    INT_REQ = 1'b1;
    repeat (3) tick();
    check("reset_ext_int", EXTERNAL_INT, 0);
    check("reset_done", INT_DONE, 0);
    check("reset_fail", INT_FAIL, 0);
    check("reset_busy", INT_BUSY, 0);
    RESETn  = 1'b1;
    INT_REQ = 1'b0;
    tick();
    check("busy_after_reset_release", INT_BUSY, 0);
    check("ext_after_reset_release", EXTERNAL_INT, 0);
    mon_en = 1'b1;
    repeat (10) tick();

    // Nominal, edge-vs-timeout boundary, timeout, three queued requests
    fresh_request();
    run_chain(5, 0);
    fresh_request();
    run_chain(HOLD_MAX - 2, 0);
    fresh_request();
    run_chain(HOLD_MAX + 2, 0);
    fresh_request();
    run_chain(9, 3);
    fresh_request();
    run_chain(HOLD_MAX + 1, 2);

    // Busy bus: CLKIN toggling every 2 cycles blocks assertion
    check("idle_before_busy_bus", INT_BUSY, 0);
    saw_high = 1'b0;
    for (int i = 0; i < 14; i++) begin
      CLKIN   = ((i / 2) % 2) == 1;
      INT_REQ = (i == 3);
      tick();
      if (EXTERNAL_INT !== 1'b0) saw_high = 1'b1;
    end
    INT_REQ = 1'b0;
    check("no_assert_on_busy_bus", saw_high, 0);
    CLKIN = 1'b1;
    wait_ext(1'b1, 40, n);
    check("rise_after_bus_settles", n, IDLE_CYCLES + 3);
    run_chain(6, 0);

    // Reset in the middle of an assertion with a request pending
    fresh_request();
    INT_REQ = 1'b1;
    tick();
    INT_REQ = 1'b0;
    tick();
    mon_e.kind = K_ABORT;
    mon_e.dur  = 0;
    sb.push_back(mon_e);
    RESETn = 1'b0;
    tick();
    check("ext_low_on_reset", EXTERNAL_INT, 0);
    check("no_done_on_reset", INT_DONE, 0);
    check("no_fail_on_reset", INT_FAIL, 0);
    tick();
    RESETn   = 1'b1;
    saw_high = 1'b0;
    repeat (20) begin
      tick();
      if (EXTERNAL_INT !== 1'b0) saw_high = 1'b1;
    end
    check("pending_dropped_by_reset", saw_high, 0);
    check("busy_after_mid_reset", INT_BUSY, 0);

    // Randomized episodes
    for (int ep = 0; ep < 25; ep++) begin
      repeat ($urandom_range(2, 10)) tick();
      fresh_request();
      run_chain(0, -1);
    end

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
